// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode and scheduler-state encodings, select screening.
package alu_pkg;

    localparam int DW    = 8;
    localparam int SEL_W = 3;

    typedef enum logic [SEL_W-1:0] {
        OP_PASS = 3'd0,
        OP_ADD  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } sched_state_e;

    // Only the four defined opcodes may reach the ALU result path.
    function automatic logic is_legal_sel(input logic [SEL_W-1:0] sel);
        return (sel <= OP_OR);
    endfunction

endpackage

// File: rtl/ALU.sv
// Purely combinational 8-bit ALU; undefined selects yield zero.
module ALU
    import alu_pkg::*;
(
    output logic signed [DW-1:0]    Result,
    input  logic signed [DW-1:0]    Data1,
    input  logic signed [DW-1:0]    Data2,
    input  logic        [SEL_W-1:0] Select
);

    always_comb begin
        Result = '0;
        case (Select)
            OP_PASS: Result = Data1;
            OP_ADD:  Result = Data1 + Data2;
            OP_AND:  Result = Data1 & Data2;
            OP_OR:   Result = Data1 | Data2;
            default: Result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting index after last_grant, with wrap.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  grant_onehot,
    output logic [IDX_W-1:0] grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        idx          = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (j == idx) && req[j]) begin
                    found           = 1'b1;
                    grant_onehot[j] = 1'b1;
                    grant_idx       = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Time-shares one ALU among NREQ requesters: round-robin grant, one op in flight,
// responses routed back to the owner with a saturating completion count.
module alu_req_scheduler
    import alu_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [DW*NREQ-1:0]     req_a,
    input  logic [DW*NREQ-1:0]     req_b,
    input  logic [SEL_W*NREQ-1:0]  req_sel,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [DW-1:0]          rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_count
);

    localparam int IDX_W = $clog2(NREQ);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    sched_state_e            state_q, state_d;
    logic signed [DW-1:0]    a_q, a_d;
    logic signed [DW-1:0]    b_q, b_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [NREQ-1:0]         gnt_oh_q, gnt_oh_d;
    logic [IDX_W-1:0]        gidx_q, gidx_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]           rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    busy_q, busy_d;
    logic [CNT_W-1:0]        op_count_q, op_count_d;

    logic [NREQ-1:0]         arb_oh;
    logic [IDX_W-1:0]        arb_idx;
    logic signed [DW-1:0]    alu_result;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req          (req_valid),
        .last_grant   (last_grant_q),
        .grant_onehot (arb_oh),
        .grant_idx    (arb_idx)
    );

    ALU u_alu (
        .Result (alu_result),
        .Data1  (a_q),
        .Data2  (b_q),
        .Select (sel_q)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        gnt_oh_d     = gnt_oh_q;
        gidx_d       = gidx_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        op_count_d   = op_count_q;
        req_ready    = '0;

        case (state_q)
            S_IDLE: begin
                req_ready = arb_oh;
                if (|req_valid) begin
                    gnt_oh_d = arb_oh;
                    gidx_d   = arb_idx;
                    for (int i = 0; i < NREQ; i++) begin
                        if (arb_oh[i]) begin
                            a_d   = req_a[i*DW +: DW];
                            b_d   = req_b[i*DW +: DW];
                            sel_d = req_sel[i*SEL_W +: SEL_W];
                        end
                    end
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Illegal selects never expose the ALU output.
                if (is_legal_sel(sel_q)) begin
                    rsp_data_d = alu_result;
                    rsp_err_d  = 1'b0;
                end else begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end
                rsp_valid_d = gnt_oh_q;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (|(rsp_ready & gnt_oh_q)) begin
                    op_count_d   = sat_inc(op_count_q);
                    last_grant_d = gidx_q;
                    rsp_valid_d  = '0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            gnt_oh_q     <= '0;
            gidx_q       <= '0;
            last_grant_q <= IDX_W'(NREQ - 1);
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_oh_q     <= gnt_oh_d;
            gidx_q       <= gidx_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
            op_count_q   <= op_count_d;
        end
    end

    // Operand latches are only meaningful after a grant, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        sel_q <= sel_d;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed and randomized bench for alu_req_scheduler against a round-robin/ALU reference model.
module tb_alu_req_scheduler;

    localparam int NREQ    = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [8*NREQ-1:0]    req_a;
    logic [8*NREQ-1:0]    req_b;
    logic [3*NREQ-1:0]    req_sel;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [7:0]           rsp_data;
    logic                 rsp_err;
    logic                 busy;
    logic [CNT_W-1:0]     op_count;

    int n_checks = 0;
    int n_fail   = 0;
    int m_last;
    int m_cnt;

    alu_req_scheduler #(
        .NREQ  (NREQ),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first valid index after the previous winner.
    function automatic int rr_ref(input int lg, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(lg + k) % NREQ]) return (lg + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        case (s)
            3'd0:    return a;
            3'd1:    return 8'((int'(a) + int'(b)) % 256);
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        req_a[i*8 +: 8]   = a;
        req_b[i*8 +: 8]   = b;
        req_sel[i*3 +: 3] = s;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy",      32'(busy),      0);
        check("rst_op_count",  32'(op_count),  0);
        check("rst_rsp_data",  32'(rsp_data),  0);
        check("rst_rsp_err",   32'(rsp_err),   0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_last = NREQ - 1;
        m_cnt  = 0;
    endtask

    // One full transaction; called at posedge+1 with the DUT idle.
    task automatic arb_round(input logic [NREQ-1:0] vmask, input int stall,
                             output int g_obs, output logic [7:0] d_obs);
        int              g;
        logic [NREQ-1:0] oh;
        logic [NREQ-1:0] rdy;
        logic [7:0]      ed;
        logic            ee;
        g   = rr_ref(m_last, vmask);
        oh  = NREQ'(1) << g;
        ee  = (req_sel[g*3 +: 3] > 3'd3);
        ed  = ee ? 8'h00 : alu_ref(req_a[g*8 +: 8], req_b[g*8 +: 8], req_sel[g*3 +: 3]);
        req_valid = vmask;
        #1;
        rdy   = req_ready;
        g_obs = -1;
        for (int i = NREQ - 1; i >= 0; i--) if (rdy[i]) g_obs = i;
        check("req_ready_grant", 32'(rdy), 32'(oh));
        @(posedge clk);
        #1;
        req_valid = vmask & ~oh;
        check("exec_busy",      32'(busy),      1);
        check("exec_req_ready", 32'(req_ready), 0);
        check("exec_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk);
        #1;
        d_obs = rsp_data;
        check("rsp_valid_owner", 32'(rsp_valid), 32'(oh));
        check("rsp_data",        32'(rsp_data),  32'(ed));
        check("rsp_err",         32'(rsp_err),   32'(ee));
        for (int s = 0; s < stall; s++) begin
            rsp_ready = ~oh;
            @(posedge clk);
            #1;
            check("stall_rsp_valid", 32'(rsp_valid), 32'(oh));
            check("stall_rsp_data",  32'(rsp_data),  32'(ed));
            check("stall_busy",      32'(busy),      1);
            check("stall_req_ready", 32'(req_ready), 0);
        end
        rsp_ready = oh;
        @(posedge clk);
        #1;
        rsp_ready = '0;
        req_valid = '0;
        m_last = g;
        m_cnt  = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        check("ack_op_count",  32'(op_count),  32'(m_cnt));
        check("ack_busy",      32'(busy),      0);
        check("ack_rsp_valid", 32'(rsp_valid), 0);
    endtask

    initial begin
        int         g;
        logic [7:0] d;
        int         cnt_before;
        int         exp_g[4];

        req_a = '0;
        req_b = '0;
        req_sel = '0;
        do_reset();

        // Single add, requester 0 wins first after reset.
        set_req(0, 8'h81, 8'h3B, 3'b001);
        arb_round(2'b01, 0, g, d);
        check("t1_grant", 32'(g), 0);
        check("t1_data",  32'(d), 32'h0BC);

        // Remaining legal opcodes and modulo-256 wrap.
        set_req(0, 8'h81, 8'h3B, 3'b000); arb_round(2'b01, 0, g, d); check("t2_pass", 32'(d), 32'h81);
        set_req(0, 8'h81, 8'h3B, 3'b010); arb_round(2'b01, 0, g, d); check("t2_and",  32'(d), 32'h01);
        set_req(0, 8'h81, 8'h3B, 3'b011); arb_round(2'b01, 0, g, d); check("t2_or",   32'(d), 32'hBB);
        set_req(1, 8'hFF, 8'h01, 3'b001); arb_round(2'b10, 0, g, d); check("t2_wrap", 32'(d), 32'h00);
        set_req(1, 8'h7F, 8'h01, 3'b001); arb_round(2'b10, 0, g, d); check("t2_ovf",  32'(d), 32'h80);

        // Contention from a fresh reset: strict alternation.
        do_reset();
        set_req(0, 8'h10, 8'h05, 3'b001);
        set_req(1, 8'h22, 8'h0F, 3'b011);
        exp_g = '{0, 1, 0, 1};
        for (int r = 0; r < 4; r++) begin
            arb_round(2'b11, 0, g, d);
            check("t3_grant_order", 32'(g), 32'(exp_g[r]));
        end
        check("t3_op_count", 32'(op_count), 4);

        // Backpressure with the other requester pending.
        set_req(0, 8'h40, 8'h02, 3'b001);
        set_req(1, 8'h55, 8'h0A, 3'b010);
        arb_round(2'b11, 5, g, d);
        check("t4_data", 32'(d), 32'h42);

        // Illegal select.
        cnt_before = int'(op_count);
        set_req(1, 8'h81, 8'h3B, 3'b101);
        arb_round(2'b10, 1, g, d);
        check("t5_data",  32'(d), 0);
        check("t5_count", 32'(op_count), 32'(cnt_before + 1));

        // Randomized traffic.
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
            end
            arb_round(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, 3), g, d);
        end

        // Reset while a response is outstanding.
        set_req(1, 8'h12, 8'h34, 3'b001);
        req_valid = 2'b10;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        check("t6_pre_rsp_valid", 32'(rsp_valid), 32'h2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_rsp_valid", 32'(rsp_valid), 0);
        check("t6_rst_busy",      32'(busy),      0);
        check("t6_rst_count",     32'(op_count),  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_last = NREQ - 1;
        m_cnt  = 0;
        set_req(0, 8'h01, 8'h02, 3'b001);
        set_req(1, 8'h03, 8'h04, 3'b001);
        arb_round(2'b11, 0, g, d);
        check("t6_first_grant", 32'(g), 0);

        // Saturation at CNT_W=4.
        for (int r = 0; r < 20; r++) begin
            set_req(r % NREQ, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
            arb_round(NREQ'(1) << (r % NREQ), 0, g, d);
        end
        check("t6_saturated", 32'(op_count), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
